unsat_clause_collector: RTL and testbench
=========================================

Name: unsat_clause_collector

Overview:
- Producer end of the clause FIFO that the unsat clause selector drains via its fifo_empty / fifo_clause inputs.
- After each variable flip, the clause evaluators stream candidate clauses with per-literal truth bits. This block keeps only the clauses that now have zero true literals, buffers them in a show-ahead FIFO, and flags the final entry of each flip batch so the controller can raise the selector's write-disable.
- It sits between the clause evaluation pipeline and the unsat clause selector.

Parameters:
NSAT, 3, literals per clause
LITERAL_ADDRESS_WIDTH, 12, bits per literal address
FIFO_DEPTH, 16, entries; power of 2, >= 2
localparam CLAUSE_WIDTH = NSAT*LITERAL_ADDRESS_WIDTH; PTR_WIDTH = $clog2(FIFO_DEPTH)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
cand_valid_i  input  1  candidate clause presented this cycle
cand_ready_o  output  1  collector accepts candidates (transfer = valid & ready)
cand_clause_i  input  CLAUSE_WIDTH  candidate clause literal addresses
cand_true_mask_i  input  NSAT  bit k = literal k true after flip
cand_last_i  input  1  final candidate of current flip batch
fifo_pop_i  input  1  selector consumed head entry
fifo_empty_o  output  1  FIFO holds no entries
fifo_clause_o  output  CLAUSE_WIDTH  head entry (show-ahead)
fifo_last_o  output  1  head entry is last unsat clause of batch
count_o  output  PTR_WIDTH+1  entries held
batch_done_o  output  1  one-cycle pulse: batch fully drained
overflow_o  output  1  sticky: unsat clause dropped, FIFO full
underflow_o  output  1  sticky: pop while empty
clear_errors_i  input  1  synchronous clear of overflow_o/underflow_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE; pointers and count 0; fifo_empty_o=1; fifo_clause_o=0; fifo_last_o=0; batch_done_o=0; overflow_o=0; underflow_o=0; cand_ready_o=1; stage register invalid. Reset asserted mid-batch discards all contents and pending last.
- Filter stage, 1 cycle:
  - An accepted candidate is registered with keep = (cand_true_mask_i == 0) and its last bit.
  - A kept clause becomes visible at the FIFO head no earlier than 2 cycles after acceptance (stage edge, then write edge).
- FSM:
  - IDLE: cand_ready_o=1. Accepted transfer -> COLLECT; if that transfer also has last -> DRAIN.
  - COLLECT: cand_ready_o=1. Accepted transfer with last -> DRAIN.
  - DRAIN: cand_ready_o=0. Leaves when the stage is invalid, the FIFO is empty, and no last entry is pending (last entry popped, or none was written). Then batch_done_o pulses for 1 cycle and the state returns to IDLE.
- Last marking, when the stage register holds the last candidate:
  - Kept: written with last=1.
  - Dropped and FIFO nonempty after this cycle's pop: the tail entry's last bit is set.
  - Dropped and FIFO empty, or the only entry is being popped this cycle: nothing is marked; DRAIN completes on emptiness.
- FIFO write/pop:
  - Write when stage valid & keep & not full. Write while full: entry dropped, overflow_o set, count unchanged.
  - Simultaneous write and pop, including when full: both occur, count unchanged.
  - Pop when empty: ignored, underflow_o set.
  - fifo_clause_o/fifo_last_o are 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH. count_o = written − popped; it never exceeds FIFO_DEPTH.
- Error flags: clear_errors_i clears both flags. A same-cycle new error event wins over the clear.
- No combinational path from fifo_pop_i to cand_ready_o.

Test Plan:
- Reset, then 4 candidates back-to-back with masks 000,010,000,000, last on the 4th → FIFO holds clauses 1,3,4. fifo_last_o=1 only when clause 4 is at the head. cand_ready_o=0 from the cycle after the 4th transfer. Pop one per cycle → batch_done_o pulses once after clause 4 is popped, then state IDLE.
- Batch where the last candidate (mask 001) is dropped after 2 kept clauses → tail entry (clause 2) carries last=1, count_o=2.
- Batch of 3 candidates, all masks nonzero → FIFO stays empty, no entry marked, batch_done_o pulses once, cand_ready_o returns to 1.
- FIFO_DEPTH=16: push 17 unsat clauses with no pops → count_o=16, overflow_o=1, clause 17 lost. clear_errors_i → overflow_o=0.
- FIFO_DEPTH=16: continuous push and pop for 40 cycles → order preserved across pointer wrap, count_o constant.
- Pop on empty → underflow_o=1. Drop rst_ni mid-COLLECT with 5 entries → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unsat_clause_collector.sv
// Filters evaluated candidate clauses down to those with no true literal and queues them
// in a show-ahead FIFO for the unsat clause selector, tagging the last entry of each flip batch.
module unsat_clause_collector #(
    parameter  int NSAT                  = 3,
    parameter  int LITERAL_ADDRESS_WIDTH = 12,
    parameter  int FIFO_DEPTH            = 16,
    localparam int CLAUSE_WIDTH          = NSAT * LITERAL_ADDRESS_WIDTH,
    localparam int PTR_WIDTH             = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cand_valid_i,
    output logic                    cand_ready_o,
    input  logic [CLAUSE_WIDTH-1:0] cand_clause_i,
    input  logic [NSAT-1:0]         cand_true_mask_i,
    input  logic                    cand_last_i,
    input  logic                    fifo_pop_i,
    output logic                    fifo_empty_o,
    output logic [CLAUSE_WIDTH-1:0] fifo_clause_o,
    output logic                    fifo_last_o,
    output logic [PTR_WIDTH:0]      count_o,
    output logic                    batch_done_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    input  logic                    clear_errors_i
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic                    stg_valid_q, stg_valid_d;
    logic                    stg_keep_q, stg_keep_d;
    logic                    stg_last_q, stg_last_d;
    logic [CLAUSE_WIDTH-1:0] stg_clause_q, stg_clause_d;
    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]      count_q, count_d;
    logic [FIFO_DEPTH-1:0]   last_q, last_d;
    logic                    pending_last_q, pending_last_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic [CLAUSE_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                    accept, empty, full, pop_en, wr_en, mark_en, stg_kept, ovf_evt;
    logic [PTR_WIDTH:0]      count_after_pop;
    logic [PTR_WIDTH-1:0]    tail_ptr;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        empty           = (count_q == '0);
        full            = (count_q == (PTR_WIDTH+1)'(FIFO_DEPTH));
        accept          = cand_valid_i & cand_ready_o;
        pop_en          = fifo_pop_i & ~empty;
        stg_kept        = stg_valid_q & stg_keep_q;
        wr_en           = stg_kept & (~full | pop_en);
        ovf_evt         = stg_kept & full & ~pop_en;
        count_after_pop = count_q - (PTR_WIDTH+1)'(pop_en);
        tail_ptr        = wr_ptr_q - PTR_WIDTH'(1);
        // A dropped last candidate (filtered out or lost to overflow) moves the tag onto the tail.
        mark_en         = stg_valid_q & stg_last_q & ~wr_en & (count_after_pop != '0);

        stg_valid_d  = accept;
        stg_keep_d   = accept & (cand_true_mask_i == '0);
        stg_last_d   = accept & cand_last_i;
        stg_clause_d = accept ? cand_clause_i : stg_clause_q;

        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_en);
        count_d  = count_after_pop + (PTR_WIDTH+1)'(wr_en);

        last_d = last_q;
        if (wr_en)   last_d[wr_ptr_q] = stg_last_q;
        if (mark_en) last_d[tail_ptr] = 1'b1;

        pending_last_d = pending_last_q;
        if (pop_en && last_q[rd_ptr_q])     pending_last_d = 1'b0;
        if ((wr_en && stg_last_q) || mark_en) pending_last_d = 1'b1;

        ovf_d = ovf_evt | (ovf_q & ~clear_errors_i);
        unf_d = (fifo_pop_i & empty) | (unf_q & ~clear_errors_i);
    end

    // Ready depends on registered state only, keeping fifo_pop_i off the candidate handshake.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        cand_ready_o = (state_q != S_DRAIN);
        unique case (state_q)
            S_IDLE: if (accept) state_d = cand_last_i ? S_DRAIN : S_COLLECT;
            S_COLLECT: if (accept && cand_last_i) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!stg_valid_q && empty && !pending_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            stg_valid_q    <= 1'b0;
            stg_keep_q     <= 1'b0;
            stg_last_q     <= 1'b0;
            stg_clause_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_q         <= '0;
            pending_last_q <= 1'b0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            stg_valid_q    <= stg_valid_d;
            stg_keep_q     <= stg_keep_d;
            stg_last_q     <= stg_last_d;
            stg_clause_q   <= stg_clause_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_q         <= last_d;
            pending_last_q <= pending_last_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
            unf_q          <= unf_d;
        end
    end

    // NOTE: the storage array is not reset; an empty FIFO masks its head, so stale data never leaks out.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= stg_clause_q;
    end

    assign fifo_empty_o  = empty;
    assign fifo_clause_o = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_last_o   = ~empty & last_q[rd_ptr_q];
    assign count_o       = count_q;
    assign batch_done_o  = done_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

endmodule

// File: tb/tb_unsat_clause_collector.sv
// Directed bench for unsat_clause_collector: per-cycle vector table plus hand-written
// overflow, pointer-wrap streaming and asynchronous mid-batch reset sequences.
module tb_unsat_clause_collector;

    localparam int CW = 36;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cand_valid_i, cand_ready_o, cand_last_i;
    logic [CW-1:0] cand_clause_i;
    logic [2:0]    cand_true_mask_i;
    logic          fifo_pop_i, fifo_empty_o, fifo_last_o;
    logic [CW-1:0] fifo_clause_o;
    logic [4:0]    count_o;
    logic          batch_done_o, overflow_o, underflow_o, clear_errors_i;

    int n_checks = 0;
    int n_fail   = 0;

    unsat_clause_collector dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cand_valid_i(cand_valid_i), .cand_ready_o(cand_ready_o),
        .cand_clause_i(cand_clause_i), .cand_true_mask_i(cand_true_mask_i),
        .cand_last_i(cand_last_i), .fifo_pop_i(fifo_pop_i),
        .fifo_empty_o(fifo_empty_o), .fifo_clause_o(fifo_clause_o),
        .fifo_last_o(fifo_last_o), .count_o(count_o),
        .batch_done_o(batch_done_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .clear_errors_i(clear_errors_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       valid;
        int         id;
        logic [2:0] mask;
        logic       last;
        logic       pop;
        logic       clr;
        int         e_count;
        int         e_head;   // 0 = FIFO expected empty
        logic       e_flast;
        logic       e_ready;
        logic       e_done;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [CW-1:0] mk(input int n);
        logic [11:0] a;
        a = 12'(n);
        return {a, a ^ 12'h5A5, a + 12'd100};
    endfunction

    function automatic vec_t v(input logic rst, valid, input int id, input logic [2:0] mask,
                               input logic last, pop, clr, input int e_count, e_head,
                               input logic e_flast, e_ready, e_done, e_ovf, e_unf);
        vec_t r;
        r.rst = rst; r.valid = valid; r.id = id; r.mask = mask; r.last = last;
        r.pop = pop; r.clr = clr; r.e_count = e_count; r.e_head = e_head;
        r.e_flast = e_flast; r.e_ready = e_ready; r.e_done = e_done;
        r.e_ovf = e_ovf; r.e_unf = e_unf;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic valid, input int id, input logic [2:0] mask,
                         input logic last, input logic pop, input logic clr);
        cand_valid_i     = valid;
        cand_clause_i    = mk(id);
        cand_true_mask_i = mask;
        cand_last_i      = last;
        fifo_pop_i       = pop;
        clear_errors_i   = clr;
    endtask

    task automatic do_reset();
        drive(0, 0, 3'b000, 0, 0, 0);
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " count"}, 64'(count_o), 64'd0);
        check({tag, " empty"}, 64'(fifo_empty_o), 64'd1);
        check({tag, " clause"}, 64'(fifo_clause_o), 64'd0);
        check({tag, " flast"}, 64'(fifo_last_o), 64'd0);
        check({tag, " ready"}, 64'(cand_ready_o), 64'd1);
        check({tag, " done"}, 64'(batch_done_o), 64'd0);
        check({tag, " ovf"}, 64'(overflow_o), 64'd0);
        check({tag, " unf"}, 64'(underflow_o), 64'd0);
    endtask

    initial begin
        int exp_id;
        int drain_ids[16];
        rst_ni = 1'b1;
        drive(0, 0, 3'b000, 0, 0, 0);
        #2;

        // rst valid id mask last pop clr | count head flast ready done ovf unf
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Batch 1: masks 000,010,000,000 with last on the 4th -> clauses 1,3,4
        tbl.push_back(v(0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 3'b010, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 3'b000, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 4, 3'b000, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 9, 3'b000, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Batch 2: last candidate dropped -> tag moves to clause 2
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 3'b000, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 3'b001, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Batch 3: nothing unsat, then underflow and its clear (error wins over clear)
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 3'b100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                drive(0, 0, 3'b000, 0, 0, 0);
                rst_ni = 1'b0;
                #1;
            end else begin
                drive(tbl[i].valid, tbl[i].id, tbl[i].mask, tbl[i].last, tbl[i].pop, tbl[i].clr);
                tick();
            end
            check($sformatf("row%0d count", i), 64'(count_o), 64'(tbl[i].e_count));
            check($sformatf("row%0d empty", i), 64'(fifo_empty_o), 64'(tbl[i].e_count == 0));
            check($sformatf("row%0d head", i), 64'(fifo_clause_o),
                  (tbl[i].e_head == 0) ? 64'd0 : 64'(mk(tbl[i].e_head)));
            check($sformatf("row%0d flast", i), 64'(fifo_last_o), 64'(tbl[i].e_flast));
            check($sformatf("row%0d ready", i), 64'(cand_ready_o), 64'(tbl[i].e_ready));
            check($sformatf("row%0d done", i), 64'(batch_done_o), 64'(tbl[i].e_done));
            check($sformatf("row%0d ovf", i), 64'(overflow_o), 64'(tbl[i].e_ovf));
            check($sformatf("row%0d unf", i), 64'(underflow_o), 64'(tbl[i].e_unf));
            if (tbl[i].rst) begin
                #1 rst_ni = 1'b1;
            end
        end

        // Overflow: 17 unsat clauses with no pops; clause 17 is lost.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            drive(1, k, 3'b000, 0, 0, 0);
            tick();
        end
        drive(0, 0, 3'b000, 0, 0, 0);
        tick();
        check("ovf count", 64'(count_o), 64'd16);
        check("ovf flag", 64'(overflow_o), 64'd1);
        check("ovf head", 64'(fifo_clause_o), 64'(mk(1)));
        drive(1, 18, 3'b000, 0, 0, 0);
        tick();
        drive(0, 0, 3'b000, 0, 0, 1);
        tick();
        check("ovf beats clear", 64'(overflow_o), 64'd1);
        tick();
        check("ovf cleared", 64'(overflow_o), 64'd0);
        drive(1, 19, 3'b000, 0, 0, 0);
        tick();
        drive(0, 0, 3'b000, 0, 1, 0);
        tick();
        check("full wr+pop count", 64'(count_o), 64'd16);
        check("full wr+pop ovf", 64'(overflow_o), 64'd0);
        drive(0, 0, 3'b000, 0, 0, 0);
        for (int j = 0; j < 15; j++) drain_ids[j] = j + 2;
        drain_ids[15] = 19;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("drain head %0d", j), 64'(fifo_clause_o), 64'(mk(drain_ids[j])));
            fifo_pop_i = 1'b1;
            tick();
        end
        fifo_pop_i = 1'b0;
        check("drain count", 64'(count_o), 64'd0);
        check("drain empty", 64'(fifo_empty_o), 64'd1);

        // Continuous push and pop across the pointer wrap with constant occupancy.
        do_reset();
        exp_id = 1;
        for (int i = 0; i < 45; i++) begin
            drive(1, i + 1, 3'b000, 0, (i >= 5), 0);
            if (i >= 5) begin
                check($sformatf("stream head %0d", i), 64'(fifo_clause_o), 64'(mk(exp_id)));
                exp_id++;
            end
            tick();
            if (i >= 5) check($sformatf("stream count %0d", i), 64'(count_o), 64'd4);
        end
        drive(0, 0, 3'b000, 0, 0, 0);

        // Underflow, then asynchronous reset mid-COLLECT with 5 entries held.
        do_reset();
        drive(0, 0, 3'b000, 0, 1, 0);
        tick();
        check("unf flag", 64'(underflow_o), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            drive(1, k, 3'b000, 0, 0, 0);
            tick();
        end
        drive(0, 0, 3'b000, 0, 0, 0);
        tick();
        check("pre-reset count", 64'(count_o), 64'd5);
        check("pre-reset head", 64'(fifo_clause_o), 64'(mk(1)));
        #3 rst_ni = 1'b0;
        #1;
        check_reset_outputs("async reset");
        #1 rst_ni = 1'b1;
        tick();
        check("post-reset count", 64'(count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
